hazard_forward_unit: RTL and testbench
======================================

// Module: hazard_forward_unit
// PURPOSE
//  Parametrised forwarding and hazard unit for the pipelined MIPS core.
//  Compares NUM_SRC ID-stage source registers against the ID_EX and EX_MEM destinations, and registers per-source forward selects aligned to the EX stage.
//  Detects load-use hazards and inserts LOAD_LAT bubbles. Freezes the pipe on a data-memory wait. Counts stall cycles.
//  Sits beside the ID_EX register; drives the EX operand muxes and the PC/IF_ID/ID_EX hold and flush controls.
// PARAMETERS
//  REG_AW   5   register-address width
//  NUM_SRC  2   source operands per instruction (channel count)
//  LOAD_LAT 1   bubbles required after a load before its consumer may enter EX (legal 1..2)
//  CNT_W    16  width of the saturating stall-cycle counter
// PORTS
//  Clk          in   1                 clock, rising edge
//  Rst_n        in   1                 asynchronous, active-low reset
//  Src_ID       in   NUM_SRC*REG_AW    ID source regs; channel i = [i*REG_AW +: REG_AW]
//  SrcUsed_ID   in   NUM_SRC           channel i is read by the ID instruction
//  Rd_ID_EX     in   REG_AW            destination in ID_EX
//  RegWrite_ID_EX in 1                 ID_EX writes a register
//  MemRead_ID_EX  in 1                 ID_EX is a load
//  Rd_EX_MEM    in   REG_AW            destination in EX_MEM
//  RegWrite_EX_MEM in 1                EX_MEM writes a register
//  MemRead_EX_MEM  in 1                EX_MEM is a load
//  Mem_busy     in   1                 data memory not ready this cycle
//  Fwd_EX       out  2*NUM_SRC         per-channel select: 00 regfile, 10 EX_MEM, 01 MEM_WB, 11 never driven
//  Stall        out  1                 hold PC and IF_ID
//  Bubble       out  1                 load NOP into ID_EX
//  Freeze       out  1                 hold every pipeline register (memory wait)
//  Stall_count  out  CNT_W             cycles with Stall=1, saturating
// BEHAVIOUR
//  Reset: Fwd_EX=0, Stall=0, Bubble=0, Freeze=0, Stall_count=0, state RUN, bubble counter=0.
//  Match(i, rd, we) = SrcUsed_ID[i] & we & (rd != 0) & (Src_ID[i] == rd).
//  Forward select, registered on each edge where Freeze=0 and Bubble=0:
//   - Match with ID_EX (rd, RegWrite) and not MemRead_ID_EX -> 10. That instruction is in EX_MEM when the consumer reaches EX.
//   - Else match with EX_MEM (rd, RegWrite) -> 01. That instruction is in MEM_WB when the consumer reaches EX.
//   - Else -> 00. The regfile is write-through, so older producers need no forwarding.
//   - Nearest producer wins. Register 0 is never forwarded.
//  On a Bubble edge: Fwd_EX <= 0 (the NOP in EX reads nothing). On a Freeze edge: Fwd_EX holds.
//  Load-use detect:
//   - LU = any i with Match(i, Rd_ID_EX, RegWrite_ID_EX) & MemRead_ID_EX -> need LOAD_LAT bubbles.
//   - LOAD_LAT=2 also: any i with Match(i, Rd_EX_MEM, RegWrite_EX_MEM) & MemRead_EX_MEM -> need 1 bubble.
//  FSM:
//   - RUN: on LU with Mem_busy=0 -> Stall=1, Bubble=1 combinationally this cycle. Load counter with need-1; go LU_STALL if need>1, else stay in RUN.
//   - LU_STALL: Stall=1, Bubble=1. Decrement counter; at 0 -> RUN.
//   - MEM_WAIT: entered from any state when Mem_busy=1. Freeze=1, Stall=1, Bubble=0; counter and forward regs hold. On Mem_busy=0, return to the saved state.
//  Mem_busy has priority over LU in the same cycle. LU is re-evaluated after the freeze.
//  Stall and Bubble are never both 0 while the state is LU_STALL. Freeze implies Bubble=0.
//  Stall_count increments every cycle Stall=1 and sticks at all-ones.
//  Reset asserted mid-stall: outputs drop to reset values immediately (async). The FSM restarts in RUN.
// STRUCTURE
//  Shared package core_pkg: FWD_REG=2'b00, FWD_EXMEM=2'b10, FWD_MEMWB=2'b01; state enum {RUN, LU_STALL, MEM_WAIT}.
//  One sub-module, fwd_match: per-channel comparator/priority encoder, instantiated NUM_SRC times by generate.
//  The FSM, bubble counter, forward registers and perf counter live in the top module.
// TESTING
//  1. add $3 in ID_EX (RegWrite=1, MemRead=0); ID src0=$3 used -> next edge Fwd_EX[1:0]=10, no stall.
//  2. Same $3 in both ID_EX and EX_MEM -> 10 (nearest wins). Src=$0 with RegWrite=1, rd=$0 -> 00.
//  3. lw $5 in ID_EX; ID src1=$5 -> Stall=1, Bubble=1 for 1 cycle. Next edge Fwd_EX=00. The following edge gives Fwd_EX[3:2]=01.
//  4. LOAD_LAT=2, same as 3 -> 2 bubble cycles, Stall_count +2. lw in EX_MEM only -> 1 bubble.
//  5. Mem_busy=1 for 3 cycles during LU_STALL -> Freeze=1, Bubble=0, counter held. Resume LU_STALL, then RUN.
//  6. Rst_n pulsed low mid LU_STALL -> all outputs 0 asynchronously. CNT_W=2 with 5 stall cycles -> Stall_count=3.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the pipeline hazard/forwarding logic: forward-select
// encodings and the hazard FSM state type.
package core_pkg;

    // Operand source seen by the EX-stage muxes.
    localparam logic [1:0] FWD_REG   = 2'b00;  // register file (write-through)
    localparam logic [1:0] FWD_EXMEM = 2'b10;  // result sitting in EX_MEM
    localparam logic [1:0] FWD_MEMWB = 2'b01;  // result sitting in MEM_WB

    // Hazard controller states.
    typedef enum logic [1:0] {
        RUN      = 2'b00,
        LU_STALL = 2'b01,
        MEM_WAIT = 2'b10
    } hz_state_e;

endpackage : core_pkg

// File: rtl/hazard_forward_unit_fwd_match.sv
// Per-channel comparator and priority encoder: decides where one ID-stage
// source operand should come from once it reaches EX, and flags load-use
// conflicts against a load in ID_EX (near) or EX_MEM (far).
module fwd_match
    import core_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] src_i,
    input  logic              used_i,
    input  logic [REG_AW-1:0] rd_id_ex_i,
    input  logic              we_id_ex_i,
    input  logic              ld_id_ex_i,
    input  logic [REG_AW-1:0] rd_ex_mem_i,
    input  logic              we_ex_mem_i,
    input  logic              ld_ex_mem_i,
    output logic [1:0]        sel_o,
    output logic              lu_near_o,
    output logic              lu_far_o
);

    localparam logic [REG_AW-1:0] REG_ZERO = {REG_AW{1'b0}};

    logic hit_id_ex_s;
    logic hit_ex_mem_s;

    // Raw register-address hits; register 0 is hard-wired and never matches.
    always_comb begin
        hit_id_ex_s  = used_i & we_id_ex_i & (rd_id_ex_i != REG_ZERO)
                       & (src_i == rd_id_ex_i);
        hit_ex_mem_s = used_i & we_ex_mem_i & (rd_ex_mem_i != REG_ZERO)
                       & (src_i == rd_ex_mem_i);
    end

    // Nearest producer wins; a load in ID_EX cannot forward, it stalls instead.
    always_comb begin
        sel_o     = FWD_REG;
        lu_near_o = 1'b0;
        lu_far_o  = 1'b0;
        if (hit_id_ex_s && !ld_id_ex_i) begin
            sel_o = FWD_EXMEM;
        end else if (hit_ex_mem_s) begin
            sel_o = FWD_MEMWB;
        end else begin
            sel_o = FWD_REG;
        end
        lu_near_o = hit_id_ex_s & ld_id_ex_i;
        lu_far_o  = hit_ex_mem_s & ld_ex_mem_i;
    end

endmodule : fwd_match

// File: rtl/hazard_forward_unit.sv
// Forwarding and hazard unit for the pipelined MIPS core. Registers per-source
// forward selects aligned to EX, inserts load-use bubbles, freezes the pipe on
// a data-memory wait and counts stall cycles.
module hazard_forward_unit
    import core_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int NUM_SRC  = 2,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic                      Clk,
    input  logic                      Rst_n,
    input  logic [NUM_SRC*REG_AW-1:0] Src_ID,
    input  logic [NUM_SRC-1:0]        SrcUsed_ID,
    input  logic [REG_AW-1:0]         Rd_ID_EX,
    input  logic                      RegWrite_ID_EX,
    input  logic                      MemRead_ID_EX,
    input  logic [REG_AW-1:0]         Rd_EX_MEM,
    input  logic                      RegWrite_EX_MEM,
    input  logic                      MemRead_EX_MEM,
    input  logic                      Mem_busy,
    output logic [2*NUM_SRC-1:0]      Fwd_EX,
    output logic                      Stall,
    output logic                      Bubble,
    output logic                      Freeze,
    output logic [CNT_W-1:0]          Stall_count
);

    localparam logic [1:0]         LAT_NEAR = 2'(LOAD_LAT);
    localparam logic [CNT_W-1:0]   CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]   CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [2*NUM_SRC-1:0] FWD_NONE = {(2*NUM_SRC){1'b0}};

    // Per-channel comparator results.
    logic [2*NUM_SRC-1:0] fwd_sel_s;
    logic [NUM_SRC-1:0]   lu_near_s;
    logic [NUM_SRC-1:0]   lu_far_s;

    // Bubbles demanded by the instruction currently in ID (0 = none).
    logic [1:0] need_s;

    // FSM and datapath registers.
    hz_state_e            state_q, state_d;
    hz_state_e            saved_q, saved_d;
    hz_state_e            eff_s;
    logic [1:0]           bcnt_q, bcnt_d;
    logic [2*NUM_SRC-1:0] fwd_q, fwd_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    // Raw (ungated) control decisions for this cycle.
    logic stall_s;
    logic bubble_s;
    logic freeze_s;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_ch
        fwd_match #(
            .REG_AW (REG_AW)
        ) u_match (
            .src_i       (Src_ID[g*REG_AW +: REG_AW]),
            .used_i      (SrcUsed_ID[g]),
            .rd_id_ex_i  (Rd_ID_EX),
            .we_id_ex_i  (RegWrite_ID_EX),
            .ld_id_ex_i  (MemRead_ID_EX),
            .rd_ex_mem_i (Rd_EX_MEM),
            .we_ex_mem_i (RegWrite_EX_MEM),
            .ld_ex_mem_i (MemRead_EX_MEM),
            .sel_o       (fwd_sel_s[2*g +: 2]),
            .lu_near_o   (lu_near_s[g]),
            .lu_far_o    (lu_far_s[g])
        );
    end

    // Bubble demand: a load in ID_EX needs the full latency; with a two-cycle
    // load a load already in EX_MEM still needs one more bubble.
    always_comb begin
        need_s = 2'd0;
        if (|lu_near_s) begin
            need_s = LAT_NEAR;
        end else if ((LOAD_LAT == 2) && (|lu_far_s)) begin
            need_s = 2'd1;
        end else begin
            need_s = 2'd0;
        end
    end

    // Hazard FSM next-state and control. MEM_WAIT resumes its saved state in
    // the same cycle memory becomes ready, so no extra dead cycle is added and
    // load-use is re-evaluated immediately after a freeze.
    always_comb begin
        state_d  = state_q;
        saved_d  = saved_q;
        bcnt_d   = bcnt_q;
        stall_s  = 1'b0;
        bubble_s = 1'b0;
        freeze_s = 1'b0;
        if (state_q == MEM_WAIT) begin
            eff_s = saved_q;
        end else begin
            eff_s = state_q;
        end

        if (Mem_busy) begin
            // Memory wait beats load-use: hold everything, bubble counter too.
            freeze_s = 1'b1;
            stall_s  = 1'b1;
            state_d  = MEM_WAIT;
            saved_d  = eff_s;
        end else begin
            case (eff_s)
                RUN: begin
                    if (need_s != 2'd0) begin
                        stall_s  = 1'b1;
                        bubble_s = 1'b1;
                        bcnt_d   = need_s - 2'd1;
                        if (need_s > 2'd1) begin
                            state_d = LU_STALL;
                        end else begin
                            state_d = RUN;
                        end
                    end else begin
                        state_d = RUN;
                    end
                end
                LU_STALL: begin
                    stall_s  = 1'b1;
                    bubble_s = 1'b1;
                    if (bcnt_q <= 2'd1) begin
                        bcnt_d  = 2'd0;
                        state_d = RUN;
                    end else begin
                        bcnt_d  = bcnt_q - 2'd1;
                        state_d = LU_STALL;
                    end
                end
                default: begin
                    bcnt_d  = 2'd0;
                    state_d = RUN;
                end
            endcase
        end
    end

    // Forward-select next value: hold on freeze, clear for a bubble NOP.
    always_comb begin
        fwd_d = fwd_q;
        if (freeze_s) begin
            fwd_d = fwd_q;
        end else if (bubble_s) begin
            fwd_d = FWD_NONE;
        end else begin
            fwd_d = fwd_sel_s;
        end
    end

    // Saturating stall-cycle counter next value.
    always_comb begin
        cnt_d = cnt_q;
        if (stall_s && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State, bubble counter, forward selects and perf counter registers.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= RUN;
            saved_q <= RUN;
            bcnt_q  <= 2'd0;
            fwd_q   <= FWD_NONE;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            saved_q <= saved_d;
            bcnt_q  <= bcnt_d;
            fwd_q   <= fwd_d;
            cnt_q   <= cnt_d;
        end
    end

    // Combinational controls are forced low while reset is held so the pipe
    // sees quiet controls immediately, not after the next edge.
    always_comb begin
        if (!Rst_n) begin
            Stall  = 1'b0;
            Bubble = 1'b0;
            Freeze = 1'b0;
        end else begin
            Stall  = stall_s;
            Bubble = bubble_s;
            Freeze = freeze_s;
        end
    end

    assign Fwd_EX      = fwd_q;
    assign Stall_count = cnt_q;

endmodule : hazard_forward_unit

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit: a per-cycle vector table for the
// single-cycle-load build plus hand sequences for two-cycle loads, memory
// freeze, asynchronous reset and counter saturation.
module tb_hazard_forward_unit;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic [9:0]  Src_ID;
    logic [1:0]  SrcUsed_ID;
    logic [4:0]  Rd_ID_EX;
    logic        RegWrite_ID_EX;
    logic        MemRead_ID_EX;
    logic [4:0]  Rd_EX_MEM;
    logic        RegWrite_EX_MEM;
    logic        MemRead_EX_MEM;
    logic        Mem_busy;

    logic [3:0]  fwd1, fwd2, fwd3;
    logic        stall1, stall2, stall3;
    logic        bubble1, bubble2, bubble3;
    logic        freeze1, freeze2, freeze3;
    logic [15:0] count1, count2;
    logic [1:0]  count3;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    hazard_forward_unit u_dut1 (
        .Clk(Clk), .Rst_n(Rst_n), .Src_ID(Src_ID), .SrcUsed_ID(SrcUsed_ID),
        .Rd_ID_EX(Rd_ID_EX), .RegWrite_ID_EX(RegWrite_ID_EX), .MemRead_ID_EX(MemRead_ID_EX),
        .Rd_EX_MEM(Rd_EX_MEM), .RegWrite_EX_MEM(RegWrite_EX_MEM), .MemRead_EX_MEM(MemRead_EX_MEM),
        .Mem_busy(Mem_busy), .Fwd_EX(fwd1), .Stall(stall1), .Bubble(bubble1),
        .Freeze(freeze1), .Stall_count(count1)
    );

    hazard_forward_unit #(.LOAD_LAT(2)) u_dut2 (
        .Clk(Clk), .Rst_n(Rst_n), .Src_ID(Src_ID), .SrcUsed_ID(SrcUsed_ID),
        .Rd_ID_EX(Rd_ID_EX), .RegWrite_ID_EX(RegWrite_ID_EX), .MemRead_ID_EX(MemRead_ID_EX),
        .Rd_EX_MEM(Rd_EX_MEM), .RegWrite_EX_MEM(RegWrite_EX_MEM), .MemRead_EX_MEM(MemRead_EX_MEM),
        .Mem_busy(Mem_busy), .Fwd_EX(fwd2), .Stall(stall2), .Bubble(bubble2),
        .Freeze(freeze2), .Stall_count(count2)
    );

    hazard_forward_unit #(.CNT_W(2)) u_dut3 (
        .Clk(Clk), .Rst_n(Rst_n), .Src_ID(Src_ID), .SrcUsed_ID(SrcUsed_ID),
        .Rd_ID_EX(Rd_ID_EX), .RegWrite_ID_EX(RegWrite_ID_EX), .MemRead_ID_EX(MemRead_ID_EX),
        .Rd_EX_MEM(Rd_EX_MEM), .RegWrite_EX_MEM(RegWrite_EX_MEM), .MemRead_EX_MEM(MemRead_EX_MEM),
        .Mem_busy(Mem_busy), .Fwd_EX(fwd3), .Stall(stall3), .Bubble(bubble3),
        .Freeze(freeze3), .Stall_count(count3)
    );

    typedef struct packed {
        logic [4:0] s0;
        logic [4:0] s1;
        logic [1:0] used;
        logic [4:0] rd_ie;
        logic       we_ie;
        logic       ld_ie;
        logic [4:0] rd_em;
        logic       we_em;
        logic       ld_em;
        logic       busy;
        logic       e_stall;
        logic       e_bubble;
        logic       e_freeze;
        logic [3:0] e_fwd;
    } vec_t;

    vec_t vecs [15];

    function automatic vec_t mk(input logic [4:0] s0, input logic [4:0] s1,
                                input logic [1:0] used,
                                input logic [4:0] rd_ie, input logic we_ie, input logic ld_ie,
                                input logic [4:0] rd_em, input logic we_em, input logic ld_em,
                                input logic busy, input logic e_stall, input logic e_bubble,
                                input logic e_freeze, input logic [3:0] e_fwd);
        vec_t v;
        v.s0 = s0; v.s1 = s1; v.used = used;
        v.rd_ie = rd_ie; v.we_ie = we_ie; v.ld_ie = ld_ie;
        v.rd_em = rd_em; v.we_em = we_em; v.ld_em = ld_em;
        v.busy = busy; v.e_stall = e_stall; v.e_bubble = e_bubble;
        v.e_freeze = e_freeze; v.e_fwd = e_fwd;
        return v;
    endfunction

    task automatic drive(input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] used,
                         input logic [4:0] rd_ie, input logic we_ie, input logic ld_ie,
                         input logic [4:0] rd_em, input logic we_em, input logic ld_em,
                         input logic busy);
        Src_ID          = {s1, s0};
        SrcUsed_ID      = used;
        Rd_ID_EX        = rd_ie;
        RegWrite_ID_EX  = we_ie;
        MemRead_ID_EX   = ld_ie;
        Rd_EX_MEM       = rd_em;
        RegWrite_EX_MEM = we_em;
        MemRead_EX_MEM  = ld_em;
        Mem_busy        = busy;
    endtask

    task automatic idle();
        drive(5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Reset pulse spanning one rising edge; returns on a falling edge.
    task automatic do_reset();
        Rst_n = 1'b0;
        idle();
        @(negedge Clk);
        Rst_n = 1'b1;
    endtask

    initial begin
        int exp_cnt;
        // s0 s1 used | rd_ie we ld | rd_em we ld | busy | stall bubble freeze | fwd after edge
        vecs[0]  = mk(5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
        vecs[1]  = mk(5'd3, 5'd0, 2'b01, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010);
        vecs[2]  = mk(5'd3, 5'd0, 2'b01, 5'd3, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010);
        vecs[3]  = mk(5'd0, 5'd0, 2'b11, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
        vecs[4]  = mk(5'd0, 5'd7, 2'b10, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0100);
        vecs[5]  = mk(5'd4, 5'd0, 2'b00, 5'd4, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
        vecs[6]  = mk(5'd4, 5'd0, 2'b01, 5'd4, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
        vecs[7]  = mk(5'd6, 5'd9, 2'b11, 5'd9, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1001);
        vecs[8]  = mk(5'd0, 5'd5, 2'b10, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000);
        vecs[9]  = mk(5'd0, 5'd5, 2'b10, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0100);
        vecs[10] = mk(5'd2, 5'd0, 2'b01, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010);
        vecs[11] = mk(5'd0, 5'd5, 2'b10, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0010);
        vecs[12] = mk(5'd0, 5'd5, 2'b10, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000);
        vecs[13] = mk(5'd0, 5'd5, 2'b10, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0100);
        vecs[14] = mk(5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);

        // Reset state
        Rst_n = 1'b0;
        idle();
        #12;
        chk("rst fwd", 32'(fwd1), 32'd0);
        chk("rst stall", 32'(stall1), 32'd0);
        chk("rst bubble", 32'(bubble1), 32'd0);
        chk("rst freeze", 32'(freeze1), 32'd0);
        chk("rst count", 32'(count1), 32'd0);
        @(negedge Clk);
        Rst_n = 1'b1;

        // Table: LOAD_LAT=1 instance, one vector per cycle
        exp_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].s0, vecs[i].s1, vecs[i].used, vecs[i].rd_ie, vecs[i].we_ie,
                  vecs[i].ld_ie, vecs[i].rd_em, vecs[i].we_em, vecs[i].ld_em, vecs[i].busy);
            #1;
            chk($sformatf("v%0d stall", i), 32'(stall1), 32'(vecs[i].e_stall));
            chk($sformatf("v%0d bubble", i), 32'(bubble1), 32'(vecs[i].e_bubble));
            chk($sformatf("v%0d freeze", i), 32'(freeze1), 32'(vecs[i].e_freeze));
            @(posedge Clk);
            #1;
            exp_cnt += int'(vecs[i].e_stall);
            chk($sformatf("v%0d fwd", i), 32'(fwd1), 32'(vecs[i].e_fwd));
            chk($sformatf("v%0d count", i), 32'(count1), 32'(exp_cnt));
            @(negedge Clk);
        end

        // Seq A: two-cycle load gives two bubbles; load in EX_MEM only gives one
        do_reset();
        drive(5'd0, 5'd5, 2'b10, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        #1; chk("A1 stall", 32'(stall2), 32'd1); chk("A1 bubble", 32'(bubble2), 32'd1);
        @(negedge Clk);
        drive(5'd0, 5'd5, 2'b10, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        #1; chk("A2 stall", 32'(stall2), 32'd1); chk("A2 bubble", 32'(bubble2), 32'd1);
        @(negedge Clk);
        drive(5'd0, 5'd5, 2'b10, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1; chk("A3 stall", 32'(stall2), 32'd0); chk("A3 fwd", 32'(fwd2), 32'd0);
        chk("A3 count", 32'(count2), 32'd2);
        @(negedge Clk);
        drive(5'd5, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        #1; chk("A4 stall", 32'(stall2), 32'd1); chk("A4 bubble", 32'(bubble2), 32'd1);
        chk("A4 lat1 stall", 32'(stall1), 32'd0);
        @(negedge Clk);
        drive(5'd5, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1; chk("A5 stall", 32'(stall2), 32'd0); chk("A5 count", 32'(count2), 32'd3);
        @(negedge Clk);

        // Seq B: memory wait during LU_STALL freezes and keeps the bubble count
        do_reset();
        drive(5'd0, 5'd5, 2'b10, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        #1; chk("B1 bubble", 32'(bubble2), 32'd1);
        @(negedge Clk);
        for (int k = 0; k < 3; k++) begin
            drive(5'd0, 5'd5, 2'b10, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1);
            #1;
            chk($sformatf("B freeze%0d", k), 32'(freeze2), 32'd1);
            chk($sformatf("B stall%0d", k), 32'(stall2), 32'd1);
            chk($sformatf("B bubble%0d", k), 32'(bubble2), 32'd0);
            @(negedge Clk);
        end
        drive(5'd0, 5'd5, 2'b00, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        #1; chk("B resume bubble", 32'(bubble2), 32'd1); chk("B resume freeze", 32'(freeze2), 32'd0);
        @(negedge Clk);
        idle();
        #1; chk("B run stall", 32'(stall2), 32'd0); chk("B count", 32'(count2), 32'd5);
        chk("B fwd", 32'(fwd2), 32'd0);
        @(negedge Clk);

        // Seq C: asynchronous reset in the middle of LU_STALL
        do_reset();
        drive(5'd0, 5'd5, 2'b10, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge Clk);
        drive(5'd0, 5'd5, 2'b10, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        #1; chk("C pre stall", 32'(stall2), 32'd1); chk("C pre count", 32'(count2), 32'd1);
        #1; Rst_n = 1'b0;
        #1;
        chk("C rst stall", 32'(stall2), 32'd0);
        chk("C rst bubble", 32'(bubble2), 32'd0);
        chk("C rst freeze", 32'(freeze2), 32'd0);
        chk("C rst fwd", 32'(fwd2), 32'd0);
        chk("C rst count", 32'(count2), 32'd0);
        @(negedge Clk);
        Rst_n = 1'b1;
        drive(5'd0, 5'd5, 2'b10, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1; chk("C after stall", 32'(stall2), 32'd0);
        @(negedge Clk);

        // Seq D: five stall cycles saturate a 2-bit counter at 3
        do_reset();
        for (int k = 0; k < 5; k++) begin
            drive(5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
            @(negedge Clk);
            if (k == 1) begin
                chk("D count3 mid", 32'(count3), 32'd2);
            end
        end
        idle();
        #1;
        chk("D count3 sat", 32'(count3), 32'd3);
        chk("D count1", 32'(count1), 32'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_hazard_forward_unit
